// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the round-robin SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW = 3;
  localparam int unsigned SRAM_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_CAP  = 2'd3
  } state_t;

  // Transaction fields captured from the winning requester at grant.
  typedef struct packed {
    logic               wr;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 #(
  parameter int unsigned FIRST_PRI = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt_c
);

  // Index of the requester granted most recently; starts pointing away from FIRST_PRI.
  logic last_q;

  // Lone requester wins; on contention the one not granted last wins.
  always_comb begin
    gnt_c = 2'b00;
    case (req)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = last_q ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
  end

  // Pointer moves to whoever was just granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= ~1'(FIRST_PRI);
    end else if (upd_en && (gnt_c != 2'b00)) begin
      last_q <= gnt_c[1];
    end
  end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Two-requester round-robin front end for the 8x32 DFF SRAM.
// Hides the SRAM's delayed read-address timing behind req/gnt/done.
module sram_rr_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW        = SRAM_AW,
  parameter int unsigned DW        = SRAM_DW,
  parameter int unsigned FIRST_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  output logic          gnt_a,
  output logic          done_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_b,
  output logic          done_b,
  output logic [DW-1:0] rdata,
  output logic          sram_we,
  output logic [AW-1:0] sram_add,
  output logic [DW-1:0] sram_wd,
  input  logic [DW-1:0] sram_rd
);

  state_t        state_q, state_d;
  req_t          cap_q, cap_d;
  req_t          win_c;
  logic          owner_q, owner_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          we_q, we_d;
  logic [DW-1:0] rdata_q;
  logic          rd_ld_c;
  logic          upd_en_c;
  logic [1:0]    arb_gnt_c;
  logic          win_b_c;

  rr_arb2 #(
    .FIRST_PRI (FIRST_PRI)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req_b, req_a}),
    .upd_en (upd_en_c),
    .gnt_c  (arb_gnt_c)
  );

  // Mux the winning requester's transaction fields.
  always_comb begin
    win_b_c     = arb_gnt_c[1];
    win_c.wr    = win_b_c ? wr_b : wr_a;
    win_c.addr  = SRAM_AW'(win_b_c ? addr_b : addr_a);
    win_c.wdata = SRAM_DW'(win_b_c ? wdata_b : wdata_a);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of all registered outputs.
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    owner_d  = owner_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    we_d     = 1'b0;
    rd_ld_c  = 1'b0;
    upd_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          upd_en_c   = 1'b1;
          owner_d    = win_b_c;
          gnt_d      = arb_gnt_c;
          cap_d.wr   = win_c.wr;
          cap_d.addr = win_c.addr;
          if (win_c.wr) begin
            // Write data only moves on writes so sram_wd holds across reads.
            cap_d.wdata = win_c.wdata;
            we_d        = 1'b1;
            state_d     = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        state_d = RD_CAP;
      end
      WR, RD_CAP: begin
        // Last cycle of a transaction: announce completion to its owner.
        done_d  = owner_q ? 2'b10 : 2'b01;
        rd_ld_c = ~cap_q.wr;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture, handshake and SRAM pin registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q   <= '0;
      owner_q <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      cap_q   <= cap_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      we_q    <= we_d;
      if (rd_ld_c) begin
        rdata_q <= sram_rd;
      end
    end
  end

  assign gnt_a    = gnt_q[0];
  assign gnt_b    = gnt_q[1];
  assign done_a   = done_q[0];
  assign done_b   = done_q[1];
  assign sram_we  = we_q;
  assign sram_add = AW'(cap_q.addr);
  assign sram_wd  = DW'(cap_q.wdata);
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Self-checking bench for sram_rr_ctrl with a behavioural SRAM and a
// transaction-level timing/data model.
module tb_sram_rr_ctrl;

  localparam int unsigned AW        = 3;
  localparam int unsigned DW        = 32;
  localparam int unsigned FIRST_PRI = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, done_a, gnt_b, done_b;
  logic [DW-1:0] rdata;
  logic          sram_we;
  logic [AW-1:0] sram_add;
  logic [DW-1:0] sram_wd;
  logic [DW-1:0] sram_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  sram_rr_ctrl #(
    .AW        (AW),
    .DW        (DW),
    .FIRST_PRI (FIRST_PRI)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .wr_a     (wr_a),
    .addr_a   (addr_a),
    .wdata_a  (wdata_a),
    .gnt_a    (gnt_a),
    .done_a   (done_a),
    .req_b    (req_b),
    .wr_b     (wr_b),
    .addr_b   (addr_b),
    .wdata_b  (wdata_b),
    .gnt_b    (gnt_b),
    .done_b   (done_b),
    .rdata    (rdata),
    .sram_we  (sram_we),
    .sram_add (sram_add),
    .sram_wd  (sram_wd),
    .sram_rd  (sram_rd)
  );

  // Behavioural 8x32 DFF SRAM: write on we, otherwise latch read address.
  logic [DW-1:0] mem [8] = '{default: '0};
  logic [AW-1:0] raddr = '0;
  always @(posedge clk) begin
    if (sram_we) mem[sram_add] <= sram_wd;
    else         raddr <= sram_add;
  end
  assign sram_rd = mem[raddr];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Cycle k is the interval following rising edge k.
  logic [DW-1:0] mmem [8] = '{default: '0};
  bit   [1:0]    e_gnt  [int];
  bit   [1:0]    e_done [int];
  logic [AW-1:0] e_add  [int];
  logic [DW-1:0] e_wd   [int];
  logic [DW-1:0] e_rd   [int];
  int            free_at = 0;
  bit            have_last = 1'b0, last_b = 1'b0;
  bit            pw_valid = 1'b0;
  int            pw_at = 0;
  logic [AW-1:0] pw_addr = '0;
  logic [DW-1:0] pw_data = '0;
  logic [DW-1:0] cur_rd = '0;
  bit            m_b, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;

  // Model: at each edge decide whether a transaction starts and schedule its effects.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      e_gnt.delete(); e_done.delete(); e_add.delete(); e_wd.delete(); e_rd.delete();
      pw_valid  = 1'b0;
      have_last = 1'b0;
      free_at   = 0;
    end else begin
      if (pw_valid && pw_at == cyc) begin
        mmem[pw_addr] = pw_data;
        pw_valid = 1'b0;
      end
      if (cyc >= free_at && (req_a || req_b)) begin
        if (req_a && req_b) m_b = have_last ? !last_b : (FIRST_PRI == 1);
        else                m_b = req_b;
        have_last = 1'b1;
        last_b    = m_b;
        m_wr   = m_b ? wr_b : wr_a;
        m_addr = m_b ? addr_b : addr_a;
        m_wd   = m_b ? wdata_b : wdata_a;
        e_gnt[cyc] = m_b ? 2'b10 : 2'b01;
        if (m_wr) begin
          e_add[cyc]   = m_addr;
          e_wd[cyc]    = m_wd;
          pw_valid     = 1'b1;
          pw_at        = cyc + 1;
          pw_addr      = m_addr;
          pw_data      = m_wd;
          e_done[cyc+1] = m_b ? 2'b10 : 2'b01;
          free_at      = cyc + 2;
        end else begin
          e_done[cyc+2] = m_b ? 2'b10 : 2'b01;
          e_rd[cyc+2]   = mmem[m_addr];
          free_at       = cyc + 3;
        end
      end
    end
  end

  // Compare every cycle, mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      cur_rd = '0;
      chk("rst_gnt",  32'({gnt_b, gnt_a}), 32'd0);
      chk("rst_done", 32'({done_b, done_a}), 32'd0);
      chk("rst_we",   32'(sram_we), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end else begin
      chk("gnt",  32'({gnt_b, gnt_a}), 32'(e_gnt.exists(cyc) ? e_gnt[cyc] : 2'b00));
      chk("done", 32'({done_b, done_a}), 32'(e_done.exists(cyc) ? e_done[cyc] : 2'b00));
      chk("sram_we", 32'(sram_we), 32'(e_add.exists(cyc)));
      if (e_add.exists(cyc)) begin
        chk("sram_add", 32'(sram_add), 32'(e_add[cyc]));
        chk("sram_wd",  sram_wd, e_wd[cyc]);
      end
      if (e_rd.exists(cyc)) cur_rd = e_rd[cyc];
      chk("rdata", rdata, cur_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input bit b, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (b) begin req_b = 1'b1; wr_b = w; addr_b = a; wdata_b = d; end
    else   begin req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d; end
  endtask

  // One transaction from one requester; waits are bounded.
  task automatic single(input bit b, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd);
    bit got = 1'b0;
    rd = '0;
    set_req(b, w, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (b ? gnt_b : gnt_a) got = 1'b1;
    end
    chk("single_gnt_seen", 32'(got), 32'd1);
    if (b) req_b = 1'b0; else req_a = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (b ? done_b : done_a) begin got = 1'b1; rd = rdata; end
    end
    chk("single_done_seen", 32'(got), 32'd1);
  endtask

  // A reads ra while B writes bd to address 7, both requesting together.
  task automatic run_pair(input logic [AW-1:0] ra, input logic [DW-1:0] bd,
                          output bit first_b, output logic [DW-1:0] rd_a);
    bit ga = 1'b0, gb = 1'b0, da = 1'b0, db = 1'b0;
    first_b = 1'b0;
    rd_a    = '0;
    set_req(1'b0, 1'b0, ra, '0);
    set_req(1'b1, 1'b1, 3'd7, bd);
    for (int i = 0; i < 30 && !(da && db); i++) begin
      tick();
      if (gnt_a) begin req_a = 1'b0; ga = 1'b1; end
      if (gnt_b) begin req_b = 1'b0; if (!ga) first_b = 1'b1; gb = 1'b1; end
      if (done_a) begin da = 1'b1; rd_a = rdata; end
      if (done_b) db = 1'b1;
    end
    chk("pair_both_done", 32'({da, db, ga, gb}), 32'hF);
  endtask

  task automatic drive_rand(input bit b, input int n);
    int gap;
    bit got;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        if (b) req_b = 1'b0; else req_a = 1'b0;
        repeat (gap) tick();
      end
      set_req(b, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom());
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        tick();
        if (b ? gnt_b : gnt_a) got = 1'b1;
      end
      chk("rand_gnt_seen", 32'(got), 32'd1);
    end
    if (b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  bit            fb;
  logic [DW-1:0] rd;
  bit   [1:0]    order [$];

  initial begin
    #1 reset = 1'b1;
    repeat (3) tick();
    chk("lit_rst_gnt",  32'({gnt_b, gnt_a}), 32'd0);
    chk("lit_rst_add",  32'(sram_add), 32'd0);
    chk("lit_rst_wd",   sram_wd, 32'd0);
    reset = 1'b0;
    tick();

    // A writes DEADBEEF to 5: gnt+we next cycle, done the cycle after.
    set_req(1'b0, 1'b1, 3'd5, 32'hDEADBEEF);
    tick();
    chk("lit_w_gnt_a", 32'(gnt_a), 32'd1);
    chk("lit_w_we",    32'(sram_we), 32'd1);
    chk("lit_w_add",   32'(sram_add), 32'd5);
    chk("lit_w_wd",    sram_wd, 32'hDEADBEEF);
    req_a = 1'b0;
    tick();
    chk("lit_w_done_a", 32'(done_a), 32'd1);
    chk("lit_w_we_off", 32'(sram_we), 32'd0);
    chk("lit_w_mem5",   mem[5], 32'hDEADBEEF);

    // A reads 5: gnt, then done with data in the third cycle.
    set_req(1'b0, 1'b0, 3'd5, 32'h0);
    tick();
    chk("lit_r_gnt_a", 32'(gnt_a), 32'd1);
    chk("lit_r_we0",   32'(sram_we), 32'd0);
    req_a = 1'b0;
    tick();
    chk("lit_r_nodone", 32'(done_a), 32'd0);
    tick();
    chk("lit_r_done_a", 32'(done_a), 32'd1);
    chk("lit_r_rdata",  rdata, 32'hDEADBEEF);

    // Reset during RD_ADDR drops the read.
    set_req(1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    chk("lit_rr_gnt_a", 32'(gnt_a), 32'd1);
    req_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("lit_rr_gnt0",   32'(gnt_a), 32'd0);
    chk("lit_rr_rdata0", rdata, 32'd0);
    chk("lit_rr_add0",   32'(sram_add), 32'd0);
    repeat (2) begin
      tick();
      chk("lit_rr_nodone", 32'({done_b, done_a}), 32'd0);
    end
    reset = 1'b0;
    tick();
    single(1'b0, 1'b0, 3'd0, 32'h0, rd);
    chk("lit_rr_read0", rd, 32'd0);

    // Fresh pointer, both held: A,B,A,B.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1'b0, 1'b0, 3'd5, 32'h0);
    set_req(1'b1, 1'b1, 3'd3, 32'h3333_0003);
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      tick();
      if (gnt_a) order.push_back(2'd0);
      if (gnt_b) order.push_back(2'd1);
      if (order.size() >= 4) begin req_a = 1'b0; req_b = 1'b0; end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (4) tick();
    chk("lit_alt_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("lit_alt_order", 32'(i < order.size() ? order[i] : 2'd3), 32'(i % 2));
    end

    // Last grant was B, so A reads 7 before B writes 1.
    run_pair(3'd7, 32'h1, fb, rd);
    chk("lit_pair1_first_b", 32'(fb), 32'd0);
    chk("lit_pair1_rdata",   rd, 32'h0);
    // After a lone A grant, B wins: A sees B's new value.
    single(1'b0, 1'b0, 3'd3, 32'h0, rd);
    chk("lit_single_r3", rd, 32'h3333_0003);
    run_pair(3'd7, 32'h2, fb, rd);
    chk("lit_pair2_first_b", 32'(fb), 32'd1);
    chk("lit_pair2_rdata",   rd, 32'h2);

    // Address extremes do not alias.
    single(1'b0, 1'b1, 3'd0, 32'h0000_A5A5, rd);
    single(1'b1, 1'b1, 3'd7, 32'h7777_0007, rd);
    single(1'b1, 1'b0, 3'd0, 32'h0, rd);
    chk("lit_wrap_rd0", rd, 32'h0000_A5A5);
    single(1'b0, 1'b0, 3'd7, 32'h0, rd);
    chk("lit_wrap_rd7", rd, 32'h7777_0007);

    // Random traffic from both requesters.
    fork
      drive_rand(1'b0, 80);
      drive_rand(1'b1, 80);
    join
    repeat (6) tick();

    for (int i = 0; i < 8; i++) chk("final_mem", mem[i], mmem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
